// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin mux-select scheduler.
//   N_CH    : number of channels (fixed at 4 by the downstream mux width)
//   SEL_W   : select width, log2(N_CH)
//   state_t : scheduler state (IDLE: nothing presented, BUSY: out_valid high)
//   onehot4 : decode a 2-bit select into a 4-bit one-hot vector
package rr_sched_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker over four requests.
//   req   [3:0] : request vector
//   start [1:0] : highest-priority channel; search order start, start+1, ... mod 4
//   any         : at least one request is set
//   idx   [1:0] : first set request in search order (0 when any=0)
module rr_pick4
    import rr_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  off;

    // Rotate so that channel 'start' lands in bit 0.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N_CH-1:0];

    // Fixed-priority pick on the rotated vector, lowest bit wins.
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
                any = 1'b1;
            end
        end
    end

    // Un-rotate; 2-bit addition wraps naturally.
    assign idx = start + off;

endmodule

// File: rtl/rr_sel_sched_4.sv
// Round-robin scheduler driving the select of a 4:1 mux with a valid/ready output.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req [3:0] : per-channel request, held until the channel's gnt bit is seen
//   out_ready : downstream accepts the mux output this cycle
//   sel [1:0] : registered mux select, stable while stalled
//   out_valid : registered, mux output is valid
//   gnt [3:0] : combinational one-hot grant, out_valid & out_ready decoded at sel
module rr_sel_sched_4
    import rr_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [N_CH-1:0]  gnt
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             accept;
    logic [N_CH-1:0]  pick_req;
    logic [SEL_W-1:0] pick_start;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    assign out_valid = (state_q == BUSY);
    assign sel       = sel_q;
    assign accept    = out_valid & out_ready;
    assign gnt       = accept ? onehot4(sel_q) : '0;

    // In the accept cycle the served channel is masked so its still-high req
    // is not served twice; search resumes just after it.
    assign pick_req   = accept ? (req & ~onehot4(sel_q)) : req;
    assign pick_start = accept ? (sel_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_sel_sched_4.sv
module tb_rr_sel_sched_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] gnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_sel;
    int m_ptr;
    bit m_valid;

    rr_sel_sched_4 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .gnt       (gnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at negedge, compare against the model, then
    // advance the model to what the following rising edge should produce.
    task automatic cycle(input logic r, input logic [3:0] q, input logic rdy, input string nm,
                         output logic [3:0] g_obs, output logic [1:0] s_obs,
                         output logic v_obs);
        logic [3:0] exp_g;
        bit found;
        @(negedge clk);
        rst = r;
        req = q;
        out_ready = rdy;
        #1;
        g_obs = gnt;
        s_obs = sel;
        v_obs = out_valid;
        exp_g = (m_valid && rdy) ? 4'(1 << m_sel) : 4'b0000;
        n_checks++;
        if (out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", nm, out_valid, m_valid);
        end
        n_checks++;
        if (sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL %s sel: got %0d expected %0d", nm, sel, m_sel);
        end
        n_checks++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL %s gnt: got %b expected %b", nm, gnt, exp_g);
        end
        if (r) begin
            m_valid = 0; m_sel = 0; m_ptr = 0;
        end else if (!m_valid) begin
            found = 0;
            for (int k = 0; k < 4; k++)
                if (!found && q[(m_ptr + k) % 4]) begin
                    found = 1; m_sel = (m_ptr + k) % 4;
                end
            m_valid = found;
        end else if (rdy) begin
            int served = m_sel;
            found = 0;
            m_ptr = (served + 1) % 4;
            for (int k = 1; k < 4; k++)
                if (!found && q[(served + k) % 4]) begin
                    found = 1; m_sel = (served + k) % 4;
                end
            m_valid = found;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req = 0; out_ready = 0;
        @(negedge clk);
        rst = 0;
        m_valid = 0; m_sel = 0; m_ptr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sel !== 2'd0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b sel=%0d gnt=%b expected v=0 sel=0 gnt=0000",
                     out_valid, sel, gnt);
        end
    endtask

    task automatic test_idle();
        logic [3:0] g; logic [1:0] s; logic v;
        for (int i = 0; i < 5; i++) cycle(0, 4'b0000, 1, "idle", g, s, v);
    endtask

    task automatic test_single_channel();
        logic [3:0] g; logic [1:0] s; logic v;
        do_reset();
        cycle(0, 4'b0100, 1, "single_c0", g, s, v);
        cycle(0, 4'b0100, 1, "single_c1", g, s, v);
        n_checks++;
        if (v !== 1'b1 || s !== 2'd2 || g !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got v=%b sel=%0d gnt=%b expected v=1 sel=2 gnt=0100",
                     v, s, g);
        end
        cycle(0, 4'b0000, 1, "single_c2", g, s, v);
        n_checks++;
        if (v !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got v=%b expected 0", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g; logic [1:0] s; logic v;
        do_reset();
        cycle(0, 4'b1111, 1, "b2b_c0", g, s, v);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4'b1111, 1, "b2b", g, s, v);
            n_checks++;
            if (v !== 1'b1 || s !== 2'(i % 4) || g !== 4'(1 << (i % 4))) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got v=%b sel=%0d gnt=%b expected v=1 sel=%0d",
                         i, v, s, g, i % 4);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] g; logic [1:0] s; logic v;
        do_reset();
        cycle(0, 4'b1010, 0, "stall_c0", g, s, v);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'b1010, 0, "stall_hold", g, s, v);
            n_checks++;
            if (v !== 1'b1 || s !== 2'd1 || g !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b sel=%0d gnt=%b expected v=1 sel=1 gnt=0000",
                         v, s, g);
            end
        end
        cycle(0, 4'b1010, 1, "stall_acc", g, s, v);
        n_checks++;
        if (g !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_accept: got gnt=%b expected 0010", g);
        end
        cycle(0, 4'b1010, 1, "stall_n1", g, s, v);
        n_checks++;
        if (s !== 2'd3 || g !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_next: got sel=%0d gnt=%b expected sel=3 gnt=1000", s, g);
        end
        cycle(0, 4'b1010, 1, "stall_n2", g, s, v);
        n_checks++;
        if (s !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_wrap: got sel=%0d expected 1", s);
        end
    endtask

    task automatic test_single_requester();
        logic [3:0] g; logic [1:0] s; logic v;
        do_reset();
        cycle(0, 4'b0001, 1, "alt_c0", g, s, v);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'b0001, 1, "alt", g, s, v);
            n_checks++;
            if (v !== ((i % 2) == 0) || g !== (((i % 2) == 0) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL alt[%0d]: got v=%b gnt=%b expected v=%0d", i, v, g, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g; logic [1:0] s; logic v;
        do_reset();
        cycle(0, 4'b0100, 0, "rmid_c0", g, s, v);
        cycle(0, 4'b0100, 0, "rmid_c1", g, s, v);
        cycle(1, 4'b0100, 1, "rmid_rst", g, s, v);
        cycle(0, 4'b1111, 1, "rmid_after", g, s, v);
        n_checks++;
        if (v !== 1'b0 || s !== 2'd0 || g !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_cleared: got v=%b sel=%0d gnt=%b expected v=0 sel=0 gnt=0000",
                     v, s, g);
        end
        cycle(0, 4'b1111, 1, "rmid_first", g, s, v);
        n_checks++;
        if (g !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_first_grant: got gnt=%b expected 0001", g);
        end
    endtask

    task automatic test_random();
        logic [3:0] g; logic [1:0] s; logic v;
        logic [3:0] cur;
        int wait_cnt [4];
        do_reset();
        cur = 0;
        for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 4; c++)
                if (!cur[c] && ($urandom_range(0, 3) == 0)) cur[c] = 1'b1;
            cycle(0, cur, 1'($urandom_range(0, 3) != 0), "rand", g, s, v);
            if (g != 0) begin
                for (int c = 0; c < 4; c++) begin
                    if (g[c]) begin
                        n_checks++;
                        if (wait_cnt[c] > 3) begin
                            n_fail++;
                            $display("FAIL fairness ch%0d: waited %0d transfers, limit 3",
                                     c, wait_cnt[c]);
                        end
                        wait_cnt[c] = 0;
                    end else if (cur[c]) begin
                        wait_cnt[c]++;
                    end
                end
            end
            // A granted channel drops its request (it may re-raise later).
            cur = cur & ~g;
        end
    endtask

    initial begin
        rst = 1; req = 0; out_ready = 0;
        m_valid = 0; m_sel = 0; m_ptr = 0;
        test_reset();
        test_idle();
        test_single_channel();
        test_back_to_back();
        test_stall();
        test_single_requester();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_sel_sched_4.md
Name: rr_sel_sched_4

Overview:
- Round-robin scheduler that sits directly upstream of the 4-way 4-bit mux (mux_4_1).
- Picks one of four requesting channels and drives the mux select. Presents a valid/ready handshake toward the consumer of the mux output.
- Returns a one-cycle grant pulse to the served channel.
- Guarantees fairness: a continuously requesting channel waits at most 3 transfers.

Parameters:
- N_CH, 4, number of channels; only 4 supported, fixed by mux width.
- SEL_W, 2, select width, equal to log2(N_CH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; a channel holds req high until it sees its gnt bit.
- out_ready  input  1  downstream accepts the current mux output this cycle.
- sel  output  2  select to mux_4_1; registered; stable while out_valid=1 and out_ready=0.
- out_valid  output  1  mux output (chosen by sel) is valid; registered.
- gnt  output  4  one-hot grant; combinational; equals out_valid & out_ready decoded at sel.

Behaviour:
- Reset (rst=1 at clock edge): sel=0, out_valid=0, ptr=0, state=IDLE. gnt=0 while out_valid=0.
- Internal pointer ptr (2 bits) marks the highest-priority channel. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (wraps 3->0).
- States: IDLE (out_valid=0) and BUSY (out_valid=1).
- IDLE:
  - If req!=0: sel <= first set bit of req in search order; out_valid <= 1; go to BUSY.
  - Latency: 1 cycle from req to out_valid.
  - If req==0: stay in IDLE.
- BUSY with out_ready=0:
  - sel and out_valid hold; gnt=0.
  - Changes in req are ignored. Dropping req[sel] early is a protocol violation; the block still holds sel.
- BUSY with out_ready=1 (accept cycle):
  - gnt[sel]=1 combinationally this cycle.
  - ptr <= sel+1 (mod 4).
  - Re-arbitrate in the same cycle over mreq = req & ~onehot(sel), searching from sel+1.
  - If mreq!=0: sel <= the pick and stay in BUSY. This gives back-to-back transfers with no bubble.
  - Else: out_valid <= 0 and go to IDLE.
- Masking the served channel in the accept cycle prevents double-serving its still-high req. Next cycle it re-arbitrates normally at lowest priority.
- At most one gnt bit is high per cycle. gnt is never high when out_valid=0.
- Throughput: 1 transfer per cycle when out_ready=1 and other channels request.
- Reset mid-operation: synchronous rst overrides any pending transfer. Outputs return to reset values at the next edge and gnt drops immediately with out_valid. No transfer counts as accepted in that cycle's successor.
- Simultaneous accept and new req on the served channel: the new req is masked for that cycle only.

Decomposition:
- Package rr_sched_pkg holds N_CH=4, SEL_W=2, the state enum (IDLE, BUSY), and a function onehot4(sel).
- One combinational sub-module, rr_pick4, fits naturally:
  - Inputs: req[3:0] and start[1:0].
  - Outputs: any, idx[1:0].
  - Implemented as a rotate, fixed-priority pick, then un-rotate.
  - Used by both IDLE and accept-cycle arbitration.
- Top level instantiates rr_pick4 once, with mux between req/mreq and ptr/sel+1.

Test Plan:
- Reset then req=0000 for 5 cycles -> out_valid=0, sel=0, gnt=0000 throughout.
- After reset, req=0100 and out_ready=1 -> next cycle out_valid=1, sel=2, gnt=0100. Channel drops req -> following cycle out_valid=0.
- req=1111 held, out_ready=1 -> sel sequence 0,1,2,3,0 on consecutive cycles; gnt 0001,0010,0100,1000,0001; no bubbles.
- req=1010, out_ready=0 for 3 cycles, then 1 -> sel=1 stable with gnt=0000 while stalled. On accept gnt=0010, next sel=3, then sel=1 again.
- Single requester req=0001 held, out_ready=1 -> transfers on alternating cycles (masked in accept cycle): out_valid 1,0,1,0; gnt=0001 on each valid cycle.
- BUSY with sel=2, out_valid=1, assert rst for 1 cycle with out_ready=1 -> next cycle out_valid=0, sel=0, ptr=0. With req=1111 after release, the first grant goes to channel 0.
